// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - register-file instruction sequencer driving a combinational ALU
// One instruction in flight: IDLE -> FETCH -> EXEC -> WB, retiring 3 cycles after accept.
module alu_sequencer #(
    parameter int NREGS  = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_op_sel,
    input  logic [7:0]        alu_result,
    input  logic [3:0]        alu_flags,
    output logic              done_valid,
    output logic [7:0]        done_result,
    output logic [3:0]        flags
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              ready_en;
    logic              accept;
    logic              host_wr;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;
    logic [7:0]        regs [NREGS];
    logic [7:0]        cap_result;
    logic [3:0]        cap_flags;
    logic [7:0]        done_result_q;
    logic [3:0]        flags_q;

    // ready_en keeps READY low until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = ready_en;
                if (instr_valid && ready_en) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB: begin
                done_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept  = instr_valid && instr_ready;
    assign host_wr = wr_en && (state == S_IDLE) && !accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (accept) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
        end
    end

    // Operands hold after WB until the next FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op_sel <= '0;
        end else if (state == S_FETCH) begin
            alu_a      <= regs[rs1_q];
            alu_b      <= regs[rs2_q];
            alu_op_sel <= op_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_result <= '0;
            cap_flags  <= '0;
        end else if (state == S_EXEC) begin
            cap_result <= alu_result;
            cap_flags  <= alu_flags;
        end
    end

    // Writeback and host preload never collide: preload is only honoured in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (state == S_WB) begin
            regs[rd_q] <= cap_result;
        end else if (host_wr) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_result_q <= '0;
            flags_q       <= '0;
        end else if (state == S_WB) begin
            done_result_q <= cap_result;
            flags_q       <= cap_flags;
        end
    end

    // The retiring value is visible in the same cycle as the DONE_VALID pulse
    assign done_result = (state == S_WB) ? cap_result : done_result_q;
    assign flags       = (state == S_WB) ? cap_flags  : flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;

    localparam int NREGS  = 4;
    localparam int REG_AW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [3:0]        instr_op = '0;
    logic [REG_AW-1:0] instr_rd = '0;
    logic [REG_AW-1:0] instr_rs1 = '0;
    logic [REG_AW-1:0] instr_rs2 = '0;
    logic              wr_en = 1'b0;
    logic [REG_AW-1:0] wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [3:0]        alu_op_sel;
    logic [7:0]        alu_result;
    logic [3:0]        alu_flags;
    logic              done_valid;
    logic [7:0]        done_result;
    logic [3:0]        flags;

    int tests_run = 0;
    int fails = 0;
    logic [7:0] model [NREGS];

    always #5 clk = ~clk;

    alu_sequencer #(.NREGS(NREGS), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op_sel(alu_op_sel),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .done_valid(done_valid), .done_result(done_result), .flags(flags)
    );

    // Behavioural ALU: returns {N,V,Z,C, result}
    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'h1: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'h2: r = a;
            default: r = a ^ b ^ {op, op};
        endcase
        return {r[7], v, (r == 8'h00), c, r};
    endfunction

    assign {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_op_sel);

    task automatic preload(input logic [REG_AW-1:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
        model[addr] = data;
    endtask

    // Issues one instruction and returns what the DUT showed; lat counts cycles accept->DONE_VALID
    task automatic run_instr(input logic [3:0] op, input logic [REG_AW-1:0] rd,
                             input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                             output logic [7:0] res, output logic [3:0] flg, output int lat,
                             output logic [7:0] a_obs, output logic [7:0] b_obs, output logic [3:0] op_obs);
        int n;
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        lat = 1; a_obs = '0; b_obs = '0; op_obs = '0;
        while (!done_valid && lat < 8) begin
            if (lat == 2) begin a_obs = alu_a; b_obs = alu_b; op_obs = alu_op_sel; end
            @(posedge clk); #1;
            lat++;
        end
        res = done_result;
        flg = flags;
        @(posedge clk); #1;
    endtask

    // Passthrough op writes the register back unchanged and exposes it on DONE_RESULT
    task automatic read_reg(input logic [REG_AW-1:0] r, output logic [7:0] v);
        logic [7:0] a, b;
        logic [3:0] f, o;
        int lat;
        run_instr(4'h2, r, r, r, v, f, lat, a, b, o);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", instr_ready); end
        tests_run++; if ({alu_a, alu_b, alu_op_sel} !== 20'h0) begin fails++; $display("FAIL reset_alu_in: got %h expected 0", {alu_a, alu_b, alu_op_sel}); end
        tests_run++; if ({done_valid, done_result, flags} !== 13'h0) begin fails++; $display("FAIL reset_done: got %h expected 0", {done_valid, done_result, flags}); end
        rst = 1'b0;
        #1;
        tests_run++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b expected 0", instr_ready); end
        @(posedge clk); #1;
        tests_run++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge: got %b expected 1", instr_ready); end
        for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            read_reg(i[REG_AW-1:0], v);
            tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL reset_reg%0d: got %h expected 00", i, v); end
        end
    endtask

    task automatic test_basic_add();
        logic [7:0] res, a, b, v;
        logic [3:0] f, o;
        int lat;
        preload(1, 8'h05);
        preload(2, 8'h03);
        run_instr(4'h0, 0, 1, 2, res, f, lat, a, b, o);
        tests_run++; if ({a, b} !== 16'h0503) begin fails++; $display("FAIL basic_operands: got %h expected 0503", {a, b}); end
        tests_run++; if (lat !== 3) begin fails++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        tests_run++; if (res !== 8'h08) begin fails++; $display("FAIL basic_result: got %h expected 08", res); end
        tests_run++; if (f !== 4'b0000) begin fails++; $display("FAIL basic_flags: got %b expected 0000", f); end
        tests_run++; if ({alu_a, alu_b} !== 16'h0503) begin fails++; $display("FAIL basic_operand_hold: got %h expected 0503", {alu_a, alu_b}); end
        tests_run++; if ({done_result, flags} !== 12'h080) begin fails++; $display("FAIL basic_done_hold: got %h expected 080", {done_result, flags}); end
        model[0] = 8'h08;
        read_reg(0, v);
        tests_run++; if (v !== 8'h08) begin fails++; $display("FAIL basic_writeback: got %h expected 08", v); end
    endtask

    task automatic test_carry_zero();
        logic [7:0] res, a, b, v;
        logic [3:0] f, o;
        int lat;
        preload(1, 8'hFF);
        preload(2, 8'h01);
        run_instr(4'h0, 3, 1, 2, res, f, lat, a, b, o);
        tests_run++; if (res !== 8'h00) begin fails++; $display("FAIL cz_result: got %h expected 00", res); end
        tests_run++; if (f !== 4'b0011) begin fails++; $display("FAIL cz_flags: got %b expected 0011", f); end
        model[3] = 8'h00;
        read_reg(3, v);
        tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL cz_writeback: got %h expected 00", v); end
    endtask

    task automatic test_overflow_dependency();
        logic [7:0] res, a, b, v;
        logic [3:0] f, o;
        int lat;
        preload(1, 8'h7F);
        preload(2, 8'h01);
        run_instr(4'h0, 1, 1, 2, res, f, lat, a, b, o);
        tests_run++; if (res !== 8'h80) begin fails++; $display("FAIL ovf_result: got %h expected 80", res); end
        tests_run++; if (f !== 4'b1100) begin fails++; $display("FAIL ovf_flags: got %b expected 1100", f); end
        run_instr(4'h0, 2, 1, 1, res, f, lat, a, b, o);
        tests_run++; if ({a, b} !== 16'h8080) begin fails++; $display("FAIL dep_operands: got %h expected 8080", {a, b}); end
        tests_run++; if (res !== 8'h00) begin fails++; $display("FAIL dep_result: got %h expected 00", res); end
        tests_run++; if (f !== 4'b0111) begin fails++; $display("FAIL dep_flags: got %b expected 0111", f); end
        model[1] = 8'h80;
        model[2] = 8'h00;
        read_reg(2, v);
        tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL dep_writeback: got %h expected 00", v); end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int dones, low_ready, acc;
        logic [7:0] v;
        dones = 0; low_ready = 0; acc = 0;
        preload(1, 8'h11);
        preload(2, 8'h22);
        instr_op = 4'h0; instr_rd = 3; instr_rs1 = 1; instr_rs2 = 2; instr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (done_valid) dones++;
            if (instr_valid && instr_ready) begin acc_cyc.push_back(c); acc++; end
            else if (instr_valid) low_ready++;
            @(posedge clk); #1;
            if (acc == 3) instr_valid = 1'b0;
        end
        tests_run++; if (acc !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d expected 3", acc); end
        if (acc_cyc.size() == 3) begin
            tests_run++; if (acc_cyc[1] - acc_cyc[0] !== 4) begin fails++; $display("FAIL b2b_gap1: got %0d expected 4", acc_cyc[1] - acc_cyc[0]); end
            tests_run++; if (acc_cyc[2] - acc_cyc[1] !== 4) begin fails++; $display("FAIL b2b_gap2: got %0d expected 4", acc_cyc[2] - acc_cyc[1]); end
        end
        tests_run++; if (low_ready !== 6) begin fails++; $display("FAIL b2b_ready_low: got %0d expected 6", low_ready); end
        tests_run++; if (dones !== 3) begin fails++; $display("FAIL b2b_done_count: got %0d expected 3", dones); end
        model[3] = 8'h33;
        read_reg(3, v);
        tests_run++; if (v !== 8'h33) begin fails++; $display("FAIL b2b_writeback: got %h expected 33", v); end
    endtask

    task automatic test_host_write();
        logic [7:0] v, expv;
        int seen;
        seen = 0;
        expv = alu_ref(model[2], model[3], 4'h0) & 12'h0FF;
        instr_op = 4'h0; instr_rd = 1; instr_rs1 = 2; instr_rs2 = 3; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wr_en = 1'b1; wr_addr = 0; wr_data = 8'hAA;
        repeat (3) begin
            if (done_valid) seen++;
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        tests_run++; if (seen !== 1) begin fails++; $display("FAIL hw_done_count: got %0d expected 1", seen); end
        model[1] = expv;
        read_reg(0, v);
        tests_run++; if (v !== model[0]) begin fails++; $display("FAIL hw_busy_ignored: got %h expected %h", v, model[0]); end
        read_reg(1, v);
        tests_run++; if (v !== model[1]) begin fails++; $display("FAIL hw_instr_result: got %h expected %h", v, model[1]); end
        instr_op = 4'h2; instr_rd = 2; instr_rs1 = 2; instr_rs2 = 2; instr_valid = 1'b1;
        wr_en = 1'b1; wr_addr = 0; wr_data = 8'h55;
        @(posedge clk); #1;
        instr_valid = 1'b0; wr_en = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        read_reg(0, v);
        tests_run++; if (v !== model[0]) begin fails++; $display("FAIL hw_handshake_ignored: got %h expected %h", v, model[0]); end
        preload(0, 8'h5A);
        read_reg(0, v);
        tests_run++; if (v !== 8'h5A) begin fails++; $display("FAIL hw_idle_write: got %h expected 5a", v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] res, a, b, v;
        logic [3:0] f, o;
        int lat, seen;
        seen = 0;
        preload(1, 8'h12);
        preload(2, 8'h34);
        instr_op = 4'h0; instr_rd = 0; instr_rs1 = 1; instr_rs2 = 2; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (alu_a !== 8'h12) begin fails++; $display("FAIL rm_exec_operand: got %h expected 12", alu_a); end
        rst = 1'b1;
        #1;
        tests_run++; if ({alu_a, alu_b, alu_op_sel} !== 20'h0) begin fails++; $display("FAIL rm_alu_cleared: got %h expected 0", {alu_a, alu_b, alu_op_sel}); end
        tests_run++; if ({instr_ready, done_valid, done_result, flags} !== 14'h0) begin fails++; $display("FAIL rm_outputs_cleared: got %h expected 0", {instr_ready, done_valid, done_result, flags}); end
        repeat (2) begin
            @(posedge clk); #1;
            if (done_valid) seen++;
        end
        rst = 1'b0;
        #1;
        if (done_valid) seen++;
        tests_run++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL rm_ready_at_release: got %b expected 0", instr_ready); end
        @(posedge clk); #1;
        if (done_valid) seen++;
        tests_run++; if (seen !== 0) begin fails++; $display("FAIL rm_no_done: got %0d expected 0", seen); end
        tests_run++; if (instr_ready !== 1'b1) begin fails++; $display("FAIL rm_ready_after: got %b expected 1", instr_ready); end
        for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
        read_reg(0, v);
        tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL rm_no_writeback: got %h expected 00", v); end
        preload(1, 8'h09);
        preload(2, 8'h04);
        run_instr(4'h1, 0, 1, 2, res, f, lat, a, b, o);
        tests_run++; if ({lat[3:0], res, f} !== 16'h3050) begin fails++; $display("FAIL rm_recover: got %h expected 3050", {lat[3:0], res, f}); end
        model[0] = 8'h05;
    endtask

    task automatic test_random();
        logic [7:0] res, a, b, v, expr;
        logic [3:0] f, o, op, expf;
        logic [REG_AW-1:0] rd, rs1, rs2;
        logic [11:0] ref_out;
        int lat;
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) == 0) preload($urandom_range(0, NREGS - 1), $urandom_range(0, 255));
            op = $urandom_range(0, 15);
            rd = $urandom_range(0, NREGS - 1);
            rs1 = $urandom_range(0, NREGS - 1);
            rs2 = $urandom_range(0, NREGS - 1);
            ref_out = alu_ref(model[rs1], model[rs2], op);
            expf = ref_out[11:8];
            expr = ref_out[7:0];
            run_instr(op, rd, rs1, rs2, res, f, lat, a, b, o);
            tests_run++; if ({a, b, o} !== {model[rs1], model[rs2], op}) begin fails++; $display("FAIL rnd%0d_operands: got %h expected %h", k, {a, b, o}, {model[rs1], model[rs2], op}); end
            tests_run++; if ({res, f} !== {expr, expf}) begin fails++; $display("FAIL rnd%0d_result: got %h expected %h", k, {res, f}, {expr, expf}); end
            model[rd] = expr;
        end
        for (int i = 0; i < NREGS; i++) begin
            read_reg(i[REG_AW-1:0], v);
            tests_run++; if (v !== model[i]) begin fails++; $display("FAIL rnd_final_reg%0d: got %h expected %h", i, v, model[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_zero();
        test_overflow_dependency();
        test_back_to_back();
        test_host_write();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
